// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive halves of the serial port.
package uart_pkg;

    localparam logic [1:0]  UART_DATA_ADDR = 2'b00;
    localparam int unsigned DATA_BITS      = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

endpackage

// File: rtl/baud_tick_cnt.sv
// Counts baud enable pulses within one bit period. The terminal-count output fires on the
// cycle of the OVERSAMPLE-th pulse after the last clear.
module baud_tick_cnt #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);

    logic [CntW-1:0] cnt_q;

    // Pulse counter; wraps naturally at the end of each bit, clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Terminal count: the pulse that completes the bit period.
    always_comb begin
        tc = en & (cnt_q == CntW'(OVERSAMPLE - 1));
    end

endmodule

// File: rtl/transmit.sv
// UART transmitter: one-entry holding buffer plus shift register, 8N1 LSB-first framing.
// Define TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module transmit
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       brg_tx_en,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tbr
);

    tx_state_t  state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic       tbr_q, tbr_d;
    logic       txd_q, txd_d;
`ifdef TX_PARITY_EN
    logic       par_q, par_d;
`endif

    logic wr_strobe;
    logic accept;
    logic load;
    logic bit_end;
    logic cnt_clr;

    // Bit timer; held clear while idle and restarted on every state change.
    baud_tick_cnt #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .en (brg_tx_en),
        .tc (bit_end)
    );

    // Decode the processor write and gate it with the registered buffer-ready flag.
    always_comb begin
        wr_strobe = iocs & ~iorw & (ioaddr == UART_DATA_ADDR);
        accept    = wr_strobe & tbr_q;
        cnt_clr   = (state_d != state_q) | (state_q == StIdle);
    end

    // Next-state, buffer handoff and registered serial output value.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tbr_d   = tbr_q;
        load    = 1'b0;
`ifdef TX_PARITY_EN
        par_d   = par_q;
`endif

        // accept needs tbr_q = 1 and load needs tbr_q = 0, so they never coincide.
        if (accept) begin
            hold_d = tx_data;
            tbr_d  = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (!tbr_q) begin
                    load    = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    idx_d   = 3'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    // Pending byte goes straight into a new start bit, no idle gap.
                    if (!tbr_q) begin
                        load    = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            shift_d = hold_q;
            tbr_d   = 1'b1;
`ifdef TX_PARITY_EN
            par_d   = ^hold_q;
`endif
        end

        // Output is derived from next state so txd changes on the same edge as the FSM.
        case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
`ifdef TX_PARITY_EN
            StParity: txd_d = par_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame and empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            hold_q  <= 8'h00;
            shift_q <= 8'h00;
            idx_q   <= 3'd0;
            tbr_q   <= 1'b1;
            txd_q   <= 1'b1;
`ifdef TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tbr_q   <= tbr_d;
            txd_q   <= txd_d;
`ifdef TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign txd = txd_q;
    assign tbr = tbr_q;

endmodule

// File: tb/tb_transmit.sv
// Self-checking bench for transmit: txd is sampled on every baud pulse and compared against
// a frame model built from the byte values (start, LSB-first data, optional parity, stop).
module tb_transmit;

    localparam int OS  = 16;
    localparam int DIV = 4;
`ifdef TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * OS * DIV;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       brg_tx_en = 1'b0;
    logic       iocs      = 1'b0;
    logic       iorw      = 1'b0;
    logic [1:0] ioaddr    = 2'b00;
    logic [7:0] tx_data   = 8'h00;
    logic       txd;
    logic       tbr;

    int   n_vec = 0;
    int   n_err = 0;
    logic samples[$];
    logic exp_q[$];

    transmit #(
        .OVERSAMPLE(OS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .brg_tx_en(brg_tx_en),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .tx_data  (tx_data),
        .txd      (txd),
        .tbr      (tbr)
    );

    always #5 clk = ~clk;

    // Baud enable: one-cycle pulse every DIV clocks.
    initial begin : brg_gen
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #2;
            brg_tx_en = (div == 0);
            div = (div + 1) % DIV;
        end
    end

    // Line monitor: record txd at every baud pulse.
    always @(negedge clk) begin
        if (brg_tx_en) samples.push_back(txd);
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    // Reference frame: each bit repeated OS pulses on the line.
    function automatic void add_frame(input logic [7:0] b);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef TX_PARITY_EN
        exp_q.push_back(^b);
`endif
        exp_q.push_back(1'b1);
    endfunction

    task automatic wait_clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] b);
        @(posedge clk);
        #2;
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = 2'b00;
        tx_data = b;
        @(posedge clk);
        #1;
        iocs    = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic wait_tbr(input string name);
        int t;
        t = 0;
        while (tbr !== 1'b1 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_vec++;
        if (t >= 100) begin
            n_err++;
            $display("FAIL %s wait_tbr: tbr=%b after 100 clocks, required 1", name, tbr);
        end
    endtask

    task automatic check_stream(input string name);
        int  i;
        bit  ok;
        i = 0;
        while (i < samples.size() && samples[i] !== 1'b0) i++;
        n_vec++;
        if (i >= samples.size()) begin
            n_err++;
            $display("FAIL %s start: no start bit in %0d samples, required a frame", name,
                     samples.size());
            return;
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            ok = (i + OS <= samples.size());
            if (ok) begin
                for (int j = 0; j < OS; j++) if (samples[i+j] !== exp_q[k]) ok = 1'b0;
            end
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL %s bit %0d: txd=%b over %0d pulses, required %b for %0d pulses",
                         name, k, (i < samples.size()) ? samples[i] : 1'bx, OS, exp_q[k], OS);
            end
            i += OS;
        end
        ok = (i < samples.size());
        for (int j = i; j < samples.size(); j++) if (samples[j] !== 1'b1) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s tail: line not idle-high after frames (%0d of %0d), required 1",
                     name, i, samples.size());
        end
    endtask

    task automatic test_reset();
        int bad;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (txd !== 1'b1) begin
            n_err++;
            $display("FAIL reset_txd: txd=%b, required 1", txd);
        end
        n_vec++;
        if (tbr !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tbr: tbr=%b, required 1", tbr);
        end
        #1 rst = 1'b0;
        bad = 0;
        // Reads and non-data addresses must not disturb the idle line.
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (txd !== 1'b1 || tbr !== 1'b1) bad++;
            #1;
            iocs    = 1'($urandom);
            ioaddr  = 2'($urandom);
            iorw    = (ioaddr == 2'b00) ? 1'b1 : 1'($urandom);
            tx_data = 8'($urandom);
        end
        @(posedge clk);
        #2;
        iocs = 1'b0;
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL idle_quiet: %0d cycles with txd/tbr not 1, required 0", bad);
        end
    endtask

    task automatic test_single(input logic [7:0] b, input string name);
        samples.delete();
        exp_q.delete();
        add_frame(b);
        do_write(b);
        n_vec++;
        if (tbr !== 1'b0) begin
            n_err++;
            $display("FAIL %s tbr_drop: tbr=%b, required 0", name, tbr);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (tbr !== 1'b1) begin
            n_err++;
            $display("FAIL %s tbr_rise: tbr=%b, required 1", name, tbr);
        end
        n_vec++;
        if (txd !== 1'b0) begin
            n_err++;
            $display("FAIL %s start_edge: txd=%b, required 0", name, txd);
        end
        wait_clocks(FRAME_CLKS + 100);
        check_stream(name);
    endtask

    task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b,
                                     input string name);
        samples.delete();
        exp_q.delete();
        add_frame(a);
        add_frame(b);
        do_write(a);
        wait_tbr(name);
        do_write(b);
        n_vec++;
        if (tbr !== 1'b0) begin
            n_err++;
            $display("FAIL %s second_accept: tbr=%b, required 0", name, tbr);
        end
        wait_clocks(2 * FRAME_CLKS + 100);
        check_stream(name);
    endtask

    task automatic test_ignored(input logic [7:0] a, input logic [7:0] b);
        samples.delete();
        exp_q.delete();
        add_frame(a);
        add_frame(b);
        do_write(a);
        wait_tbr("ignored");
        do_write(b);
        do_write(8'h55);
        n_vec++;
        if (tbr !== 1'b0) begin
            n_err++;
            $display("FAIL ignored_tbr: tbr=%b after dropped write, required 0", tbr);
        end
        wait_clocks(2 * FRAME_CLKS + 100);
        check_stream("ignored");
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'($urandom) & 8'hEF;
        do_write(b);
        @(posedge clk);
        #1;
        do_write(8'($urandom));
        // Data bit 4 spans roughly clocks 320..384 after the start bit.
        repeat (350) @(posedge clk);
        #3;
        n_vec++;
        if (txd !== 1'b0 || tbr !== 1'b0) begin
            n_err++;
            $display("FAIL mid_frame: txd=%b tbr=%b, required 0 0 in data bit 4", txd, tbr);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (txd !== 1'b1 || tbr !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: txd=%b tbr=%b, required 1 1", txd, tbr);
        end
        samples.delete();
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        wait_clocks(1000);
        begin : residue
            bit ok;
            ok = (samples.size() > 0);
            foreach (samples[j]) if (samples[j] !== 1'b1) ok = 1'b0;
            n_vec++;
            if (!ok || tbr !== 1'b1) begin
                n_err++;
                $display("FAIL residual_frame: line or tbr disturbed (tbr=%b), required idle",
                         tbr);
            end
        end
    endtask

    initial begin : main
        logic [7:0] a;
        logic [7:0] b;
        test_reset();
        test_single(8'hA5, "single_a5");
        for (int r = 0; r < 3; r++) test_single(8'($urandom), "single_rand");
        test_back_to_back(8'h3C, 8'hC3, "b2b_3c_c3");
        test_back_to_back(8'($urandom), 8'($urandom), "b2b_rand");
        a = 8'($urandom);
        b = 8'($urandom);
        if (b == 8'h55) b = 8'hAA;
        test_ignored(a, b);
        test_reset_mid();
        test_single(8'($urandom), "after_reset");
`ifdef TX_PARITY_EN
        test_single(8'h07, "parity_07");
        test_single(8'h03, "parity_03");
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
